// File: rtl/spi_frame_in_if.sv
// Frame-buffer write port and downstream send handshake of spi_frame_in.
// The master side writes the buffer and raises send; the slave side reports busy.
interface spi_frame_in_if #(
    parameter int addr_width = 9,
    parameter int data_width = 8
);
    logic [data_width-1:0] wdata;
    logic [addr_width-1:0] waddr;
    logic                  we;
    logic                  send;
    logic                  busy;

    modport master (output wdata, output waddr, output we, output send, input busy);
    modport slave  (input wdata, input waddr, input we, input send, output busy);
endinterface

// File: rtl/spi_frame_in.sv
// SPI slave front end: writes one LED frame into the circular frame buffer and hands it downstream.
// Define SPI_FRAME_IN_CHECKSUM_EN to require a trailing XOR checksum byte after the data bytes.
module spi_frame_in #(
    parameter int addr_width = 9,
    parameter int data_width = 8,
    parameter int n_LEDS     = 320,
    parameter int buf_depth  = 512
) (
    input  logic clk_sys,
    input  logic n_rst,
    input  logic spi_sck,
    input  logic spi_mosi,
    input  logic spi_ncs,
    output logic err_len,
    output logic err_ovr,
    spi_frame_in_if.master bus
);
    localparam int BW = (data_width > 1) ? $clog2(data_width) : 1;
    localparam int CW = $clog2(n_LEDS + 2);
    localparam logic [BW-1:0]         LAST_BIT  = BW'(data_width - 1);
    localparam logic [CW-1:0]         N_C       = CW'(n_LEDS);
    localparam logic [CW-1:0]         SAT_C     = CW'(n_LEDS + 1);
    localparam logic [addr_width-1:0] LAST_ADDR = addr_width'(buf_depth - 1);

    typedef enum logic [1:0] {IDLE, RECV, COMMIT} state_t;

    logic sck_meta_q, sck_sync_q, sck_prev_q;
    logic ncs_meta_q, ncs_sync_q, ncs_prev_q;
    logic mosi_meta_q, mosi_sync_q;

    state_t                state_q, state_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]         byte_cnt_q, byte_cnt_d;
    logic [data_width-2:0] shift_q, shift_d;
    logic [addr_width-1:0] frame_base_q, frame_base_d;
    logic [addr_width-1:0] waddr_q, waddr_d;
    logic [data_width-1:0] wdata_q, wdata_d;
    logic                  we_q, we_d;
    logic                  send_q, send_d;
    logic                  err_len_q, err_len_d;
    logic                  err_ovr_q, err_ovr_d;
`ifdef SPI_FRAME_IN_CHECKSUM_EN
    logic [data_width-1:0] csum_q, csum_d;
    logic                  extra_q, extra_d;
`endif

    logic                  sck_rise, ncs_rise, ncs_fall;
    logic                  frame_ok, start_frame;
    logic [data_width-1:0] byte_next;

    function automatic logic [addr_width-1:0] addr_inc(input logic [addr_width-1:0] a);
        return (a == LAST_ADDR) ? '0 : a + 1'b1;
    endfunction

    // Two flops per async pin plus one history flop for edge detection.
    always_ff @(posedge clk_sys or negedge n_rst) begin
        if (!n_rst) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            ncs_meta_q  <= 1'b1;
            ncs_sync_q  <= 1'b1;
            ncs_prev_q  <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the chain really is two stages deep.
            sck_meta_q  <= spi_sck;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            ncs_meta_q  <= spi_ncs;
            ncs_sync_q  <= ncs_meta_q;
            ncs_prev_q  <= ncs_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    assign sck_rise  = sck_sync_q & ~sck_prev_q;
    assign ncs_rise  = ncs_sync_q & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_sync_q & ncs_prev_q;
    assign byte_next = {shift_q, mosi_sync_q};

`ifdef SPI_FRAME_IN_CHECKSUM_EN
    // The running XOR includes the trailer, so a matching trailer leaves zero.
    assign frame_ok = (byte_cnt_q == SAT_C) && (bit_cnt_q == '0) && (csum_q == '0) && !extra_q;
`else
    assign frame_ok = (byte_cnt_q == N_C) && (bit_cnt_q == '0);
`endif

    always_comb begin
        // NOTE: every signal gets a default first, so no path through the case can infer a latch.
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        shift_d      = shift_q;
        frame_base_d = frame_base_q;
        waddr_d      = waddr_q;
        wdata_d      = wdata_q;
        we_d         = 1'b0;
        send_d       = 1'b0;
        err_len_d    = 1'b0;
        err_ovr_d    = err_ovr_q;
        start_frame  = 1'b0;
`ifdef SPI_FRAME_IN_CHECKSUM_EN
        csum_d       = csum_q;
        extra_d      = extra_q;
`endif
        case (state_q)
            IDLE: begin
                if (ncs_fall) start_frame = 1'b1;
            end
            RECV: begin
                if (ncs_rise) begin
                    if (frame_ok) begin
                        state_d = COMMIT;
                    end else begin
                        state_d   = IDLE;
                        err_len_d = 1'b1;
                        waddr_d   = frame_base_q;
                    end
                end else if (sck_rise) begin
                    shift_d = byte_next[data_width-2:0];
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        if (byte_cnt_q < N_C) begin
                            we_d    = 1'b1;
                            waddr_d = addr_inc(waddr_q);
                            wdata_d = byte_next;
                        end
                        if (byte_cnt_q != SAT_C) byte_cnt_d = byte_cnt_q + 1'b1;
`ifdef SPI_FRAME_IN_CHECKSUM_EN
                        // The counter saturates one past the trailer; a byte arriving there is an overrun.
                        if (byte_cnt_q == SAT_C) extra_d = 1'b1;
                        else                     csum_d  = csum_q ^ byte_next;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                if (!bus.busy) begin
                    send_d  = 1'b1;
                    state_d = IDLE;
                    if (ncs_fall) start_frame = 1'b1;
                end else if (ncs_fall) begin
                    err_ovr_d   = 1'b1;
                    start_frame = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The current waddr is the rewind point if the new frame turns out bad.
        if (start_frame) begin
            state_d      = RECV;
            bit_cnt_d    = '0;
            byte_cnt_d   = '0;
            frame_base_d = waddr_q;
`ifdef SPI_FRAME_IN_CHECKSUM_EN
            csum_d       = '0;
            extra_d      = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk_sys or negedge n_rst) begin
        if (!n_rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            frame_base_q <= '0;
            waddr_q      <= LAST_ADDR;
            wdata_q      <= '0;
            we_q         <= 1'b0;
            send_q       <= 1'b0;
            err_len_q    <= 1'b0;
            err_ovr_q    <= 1'b0;
`ifdef SPI_FRAME_IN_CHECKSUM_EN
            csum_q       <= '0;
            extra_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            shift_q      <= shift_d;
            frame_base_q <= frame_base_d;
            waddr_q      <= waddr_d;
            wdata_q      <= wdata_d;
            we_q         <= we_d;
            send_q       <= send_d;
            err_len_q    <= err_len_d;
            err_ovr_q    <= err_ovr_d;
`ifdef SPI_FRAME_IN_CHECKSUM_EN
            csum_q       <= csum_d;
            extra_q      <= extra_d;
`endif
        end
    end

    assign bus.wdata = wdata_q;
    assign bus.waddr = waddr_q;
    assign bus.we    = we_q;
    assign bus.send  = send_q;
    assign err_len   = err_len_q;
    assign err_ovr   = err_ovr_q;
endmodule

// File: tb/tb_spi_frame_in.sv
// Bench for spi_frame_in with a shrunk frame (24 bytes) and a non-power-of-two buffer (40 words),
// so wrap-around and every error path are reached within a short run.
module tb_spi_frame_in;
    localparam int AW = 6;
    localparam int DW = 8;
    localparam int N  = 24;
    localparam int D  = 40;
`ifdef SPI_FRAME_IN_CHECKSUM_EN
    localparam int FLEN = N + 1;
`else
    localparam int FLEN = N;
`endif

    typedef enum {O_ERR, O_SEND, O_DROP, O_NONE} outcome_t;
    typedef struct {
        int       nbytes;
        int       ntail;
        bit       bad;
        int       busy_hold;
        outcome_t outc;
    } vec_t;
    typedef struct {
        int a;
        int d;
    } wr_t;

    logic clk_sys  = 1'b0;
    logic n_rst    = 1'b0;
    logic spi_sck  = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_ncs  = 1'b1;
    logic err_len, err_ovr;

    spi_frame_in_if #(.addr_width(AW), .data_width(DW)) bus ();

    spi_frame_in #(.addr_width(AW), .data_width(DW), .n_LEDS(N), .buf_depth(D)) dut (
        .clk_sys (clk_sys),
        .n_rst   (n_rst),
        .spi_sck (spi_sck),
        .spi_mosi(spi_mosi),
        .spi_ncs (spi_ncs),
        .err_len (err_len),
        .err_ovr (err_ovr),
        .bus     (bus.master)
    );

    always #5 clk_sys = ~clk_sys;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observed traffic, collected on the falling edge.
    wr_t obs_wr[$];
    wr_t exp_wr[$];
    int  obs_send[$];
    int  exp_send[$];
    int  obs_err = 0;
    int  exp_err = 0;
    int  collide = 0;

    always @(negedge clk_sys) begin
        if (n_rst) begin
            if (bus.we) begin
                wr_t w;
                w.a = int'(bus.waddr);
                w.d = int'(bus.wdata);
                obs_wr.push_back(w);
            end
            if (bus.send) obs_send.push_back(int'(bus.waddr));
            if (err_len) obs_err++;
            if (bus.we && bus.send) collide++;
        end
    end

    // Reference model: the buffer is a ring of D words; a frame occupies the words after the
    // last committed address; a bad frame leaves the committed address unchanged.
    int         m_waddr;
    logic [7:0] stream_q[$];

    task automatic build_stream(input int nbytes, input int off, input bit rnd, input bit bad);
        logic [7:0] x = 8'h00;
        logic [7:0] b;
        stream_q.delete();
        for (int i = 0; i < nbytes; i++) begin
            b = rnd ? 8'($urandom_range(0, 255)) : 8'((i + off) % 256);
            stream_q.push_back(b);
            x ^= b;
        end
`ifdef SPI_FRAME_IN_CHECKSUM_EN
        stream_q.push_back(x ^ {7'b0, bad});
`else
        if (bad) x = 8'h00;
`endif
    endtask

    function automatic bit frame_valid(input int ntail);
        logic [7:0] x = 8'h00;
        foreach (stream_q[i]) x ^= stream_q[i];
`ifdef SPI_FRAME_IN_CHECKSUM_EN
        return (ntail == 0) && (stream_q.size() == FLEN) && (x == 8'h00);
`else
        return (ntail == 0) && (stream_q.size() == FLEN);
`endif
    endfunction

    task automatic model_frame(input int nfull, input outcome_t o);
        int  base = m_waddr;
        wr_t w;
        for (int i = 0; i < nfull && i < N; i++) begin
            w.a = (base + 1 + i) % D;
            w.d = int'(stream_q[i]);
            exp_wr.push_back(w);
        end
        case (o)
            O_SEND: begin m_waddr = (base + N) % D; exp_send.push_back(m_waddr); end
            O_DROP: m_waddr = (base + N) % D;
            O_ERR:  exp_err++;
            default: ;
        endcase
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Mode 0, MSB first: data changes while sck is low, sampled on the rising edge.
    task automatic spi_bits(input int nfull, input int ntail, input int h);
        logic [7:0] cur;
        int nb;
        for (int i = 0; i < nfull + (ntail > 0 ? 1 : 0); i++) begin
            cur = (i < stream_q.size()) ? stream_q[i] : 8'($urandom_range(0, 255));
            nb  = (i < nfull) ? 8 : ntail;
            for (int b = 0; b < nb; b++) begin
                spi_mosi = cur[7-b];
                tick(h);
                spi_sck = 1'b1;
                tick(h);
                spi_sck = 1'b0;
            end
        end
    endtask

    task automatic spi_frame(input int nfull, input int ntail, input int h);
        spi_ncs = 1'b0;
        tick(h);
        spi_bits(nfull, ntail, h);
        tick(h);
        spi_ncs = 1'b1;
        tick(h + 4);
    endtask

    task automatic compare_results(input string tag);
        tick(6);
        check({tag, ".wr_count"}, obs_wr.size(), exp_wr.size());
        for (int i = 0; i < obs_wr.size() && i < exp_wr.size(); i++) begin
            check({tag, ".wr_addr"}, obs_wr[i].a, exp_wr[i].a);
            check({tag, ".wr_data"}, obs_wr[i].d, exp_wr[i].d);
        end
        check({tag, ".send_count"}, obs_send.size(), exp_send.size());
        for (int i = 0; i < obs_send.size() && i < exp_send.size(); i++)
            check({tag, ".send_waddr"}, obs_send[i], exp_send[i]);
        check({tag, ".err_len_count"}, obs_err, exp_err);
        check({tag, ".waddr_rest"}, bus.waddr, m_waddr);
        obs_wr.delete();
        exp_wr.delete();
        obs_send.delete();
        exp_send.delete();
        obs_err = 0;
        exp_err = 0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".waddr"}, bus.waddr, D - 1);
        check({tag, ".wdata"}, bus.wdata, 0);
        check({tag, ".we"}, bus.we, 0);
        check({tag, ".send"}, bus.send, 0);
        check({tag, ".err_len"}, err_len, 0);
        check({tag, ".err_ovr"}, err_ovr, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        vecs[0] = '{N,     0, 1'b0, 0,   O_SEND};   // first frame at 0..N-1
        vecs[1] = '{N,     0, 1'b0, 0,   O_SEND};   // second frame wraps the ring
        vecs[2] = '{N - 1, 0, 1'b0, 0,   O_ERR};    // one byte short
        vecs[3] = '{N,     3, 1'b0, 0,   O_ERR};    // trailing partial byte
        vecs[4] = '{N + 1, 0, 1'b0, 0,   O_ERR};    // one byte too many
        vecs[5] = '{0,     0, 1'b0, 0,   O_ERR};    // empty chip-select pulse
        vecs[6] = '{N,     0, 1'b0, 100, O_SEND};   // downstream busy for 100 cycles
`ifdef SPI_FRAME_IN_CHECKSUM_EN
        vecs[7] = '{N,     0, 1'b1, 0,   O_ERR};    // corrupted checksum trailer
`else
        vecs[7] = '{N,     0, 1'b1, 0,   O_SEND};
`endif

        bus.busy = 1'b0;
        tick(3);
        check_reset_values("reset");
        n_rst = 1'b1;
        m_waddr = D - 1;
        tick(3);

        foreach (vecs[k]) begin
            build_stream(vecs[k].nbytes, k * 13, 1'b0, vecs[k].bad);
            bus.busy = (vecs[k].busy_hold > 0);
            spi_frame(vecs[k].nbytes + (FLEN - N), vecs[k].ntail, 2);
            if (vecs[k].busy_hold > 0) begin
                tick(vecs[k].busy_hold);
                check("vec.send_held_by_busy", obs_send.size(), 0);
                bus.busy = 1'b0;
                @(negedge clk_sys);
                check("vec.send_not_before_edge", bus.send, 0);
                @(negedge clk_sys);
                check("vec.send_after_busy_fall", bus.send, 1);
            end
            model_frame(vecs[k].nbytes + (FLEN - N), vecs[k].outc);
            compare_results($sformatf("vec%0d", k));
        end

        // A new transaction while a frame waits on busy drops the waiting frame.
        check("ovr.err_ovr_clear", err_ovr, 0);
        bus.busy = 1'b1;
        build_stream(N, 0, 1'b1, 1'b0);
        spi_frame(FLEN, 0, 2);
        model_frame(FLEN, O_DROP);
        tick(20);
        check("ovr.no_send_while_busy", obs_send.size(), 0);
        build_stream(N, 0, 1'b1, 1'b0);
        spi_frame(FLEN, 0, 3);
        model_frame(FLEN, O_SEND);
        check("ovr.err_ovr_set", err_ovr, 1);
        bus.busy = 1'b0;
        compare_results("ovr");
        check("ovr.err_ovr_sticky", err_ovr, 1);

        // Randomised frames: mostly valid, with occasional length, tail and checksum faults.
        for (int r = 0; r < 16; r++) begin
            int pick  = $urandom_range(0, 9);
            int nb    = (pick == 6) ? N - 1 : (pick == 7) ? N + 1 : N;
            int ntail = (pick == 8) ? $urandom_range(1, 7) : 0;
            int h     = $urandom_range(2, 4);
            int hold  = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            bit ok;
            build_stream(nb, 0, 1'b1, pick == 9);
            ok = frame_valid(ntail);
            bus.busy = (hold > 0);
            spi_frame(stream_q.size(), ntail, h);
            if (hold > 0) begin
                tick(hold);
                check("rnd.send_held_by_busy", obs_send.size(), 0);
                bus.busy = 1'b0;
            end
            model_frame(stream_q.size(), ok ? O_SEND : O_ERR);
            compare_results($sformatf("rnd%0d", r));
        end

        // Reset in the middle of a frame, then a full frame starts again at address 0.
        build_stream(N, 0, 1'b1, 1'b0);
        spi_ncs = 1'b0;
        tick(2);
        spi_bits(N / 2, 3, 2);
        n_rst = 1'b0;
        #1;
        check_reset_values("midrst");
        model_frame(N / 2, O_NONE);
        m_waddr = D - 1;
        spi_ncs = 1'b1;
        spi_sck = 1'b0;
        compare_results("midrst");
        n_rst = 1'b1;
        tick(3);
        build_stream(N, 5, 1'b0, 1'b0);
        spi_frame(FLEN, 0, 2);
        model_frame(FLEN, O_SEND);
        compare_results("after_rst");

        check("we_send_exclusive", collide, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/spi_frame_in.md
Name: spi_frame_in

Overview:
- SPI slave front end that receives one LED frame from the host MCU, byte by byte.
- Writes the bytes into the shared circular frame buffer.
- On a complete, valid frame, pulses send to the downstream SPI output stage, presenting on waddr the address of the frame's last byte. The downstream stage computes the frame start as waddr - (n_LEDS - 1).
- Runs entirely in the clk_sys domain; the external SPI pins are synchronised internally.

Parameters:
- addr_width, 9, frame buffer address width.
- data_width, 8, bits per received byte / buffer word.
- n_LEDS, 320, bytes per valid frame.
- buf_depth, 512, buffer words; wrap modulus for waddr; must be >= 2*n_LEDS is NOT required, must be >= n_LEDS.

Ports:
- clk_sys  input  1  system clock; must be >= 4x spi_sck frequency.
- n_rst  input  1  asynchronous active-low reset.
- spi_sck  input  1  host SPI clock (async, mode 0, data sampled on rising edge, MSB first).
- spi_mosi  input  1  host serial data (async).
- spi_ncs  input  1  host chip select, active low (async).
- busy  input  1  downstream stage is still sending the previous frame.
- wdata  output  data_width  byte to write.
- waddr  output  addr_width  write address; address of the most recent write.
- we  output  1  buffer write strobe, 1 cycle.
- send  output  1  frame-ready pulse, 1 cycle.
- err_len  output  1  1-cycle pulse: frame discarded (wrong length or partial byte).
- err_ovr  output  1  sticky: pending frame dropped by a new transaction; cleared only by reset.

Behaviour:
- Reset values (n_rst low, async): wdata=0, we=0, send=0, err_len=0, err_ovr=0, waddr=buf_depth-1 (first write lands at 0), state=IDLE, all counters=0, sync flops: ncs=1, sck=0.
- Synchronisation:
  - 2-flop synchronisers on sck, mosi and ncs.
  - sck rise = synced sck high and previous synced sample low; ncs edges are detected the same way.
- Shifter: on each sck rise while in RECV, shift synced mosi in LSB-side (MSB first) and increment bit_cnt (0..7).
- Byte complete (8th rise):
  - If byte_cnt < n_LEDS: in the next cycle we=1, waddr<=(waddr+1) mod buf_depth, wdata=assembled byte.
  - Increment byte_cnt, saturating at n_LEDS+1.
  - Bytes beyond n_LEDS are not written.
- Latency: we asserts 1 clk_sys cycle after the cycle in which the 8th sck rise is detected.
- States:
  - IDLE: on ncs fall -> RECV; clear bit_cnt and byte_cnt; frame_base<=waddr (the rewind point).
  - RECV: on ncs rise:
    - If byte_cnt==n_LEDS and bit_cnt==0 -> COMMIT.
    - Otherwise -> IDLE, err_len pulse, waddr<=frame_base (partial frame rewound).
    - An sck rise coincident with the ncs rise is ignored.
  - COMMIT:
    - When busy==0: send=1 for one cycle, waddr held at the last frame byte -> IDLE.
    - While busy==1: wait with waddr held.
    - On ncs fall while waiting: drop the pending frame, set err_ovr, frame_base<=waddr, -> RECV (the dropped frame stays in the buffer but is never sent).
- send and we are never high in the same cycle.
- waddr changes only on writes, rewinds or reset.
- Address arithmetic wraps modulo buf_depth; if buf_depth is a power of two, a natural overflow is acceptable.
- Reset mid-frame: immediate return to reset values; no send.

Optional Feature:
- Macro SPI_FRAME_IN_CHECKSUM_EN.
- Defined:
  - A valid frame is n_LEDS data bytes plus one trailing checksum byte.
  - The trailer must equal the XOR of all data bytes; it is not written to the buffer.
  - Commit requires byte_cnt==n_LEDS+1 and a checksum match.
  - A checksum mismatch -> err_len pulse and rewind, same as a length error.
- Undefined: no checksum; exactly n_LEDS bytes are required; a trailing extra byte is a length error.

Test Plan:
- Reset, then one frame of 320 bytes with value i mod 256, busy=0 -> 320 we pulses at addresses 0..319 with matching data; one send pulse with waddr=319; err_len=0.
- Two consecutive valid frames -> second frame written at 320..511 then 0..127 (wrap); send with waddr=127.
- Frame of 319 bytes, then a frame of 320 bytes plus 3 bits -> err_len pulse each time, no send, waddr rewound to 319 after the prior valid frame.
- Valid frame with busy=1 held for 100 cycles -> send is issued the cycle after busy falls. A repeat with a new ncs fall during busy -> no send, err_ovr=1, new frame accepted normally.
- Assert n_rst low during byte 150 -> outputs return to reset values immediately; the following full frame writes from address 0.
- With SPI_FRAME_IN_CHECKSUM_EN: correct XOR trailer -> send with waddr=319; trailer XOR 0x01 -> err_len, no send.
